// File: rtl/pkt_rx_framer.sv
`default_nettype none
// ============================================================================
//  Module   : pkt_rx_framer
//  Purpose  : Byte-level packet receiver/validator. Parses START / SRC / DST /
//             CNT / TYPE / LEN / DATA / CRC / STOP frames, checks address,
//             counter monotonicity and CRC-8, buffers the payload and releases
//             it on a ready/valid stream only after the whole frame is good.
//  Revision : 1.0 - initial release
// ============================================================================
module pkt_rx_framer #(
    parameter int         ADDR_BYTES  = 2,
    parameter int         CNT_BYTES   = 4,
    parameter int         MAX_PAYLOAD = 16,
    parameter logic [7:0] START_BYTE  = 8'hAA,
    parameter logic [7:0] STOP_BYTE   = 8'h55,
    parameter int         DELIM_LEN   = 2,
    parameter logic [7:0] CRC_POLY    = 8'h07,
    parameter int         TMOUT_CYC   = 5000000,
    parameter bit         BCAST_EN    = 1'b1
) (
    input  logic                    ref_clk,
    input  logic                    reset,
    input  logic [8*ADDR_BYTES-1:0] dev_addr,
    input  logic [7:0]              in_data,
    input  logic                    in_valid,
    input  logic                    in_par_err,
    output logic                    in_ready,
    output logic [7:0]              out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_last,
    output logic [7:0]              out_type,
    output logic [8*ADDR_BYTES-1:0] out_src,
    output logic                    valid_intr,
    output logic [2:0]              err_code,
    output logic                    err_valid
);

    localparam int AW    = 8 * ADDR_BYTES;
    localparam int CW    = 8 * CNT_BYTES;
    localparam int IDX_W = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
    localparam int TW    = $clog2(TMOUT_CYC + 1);

    localparam logic [7:0]    c_addr_last  = 8'(ADDR_BYTES - 1);
    localparam logic [7:0]    c_cnt_last   = 8'(CNT_BYTES - 1);
    localparam logic [7:0]    c_delim_last = 8'(DELIM_LEN - 1);
    localparam logic [8:0]    c_max_len    = 9'(MAX_PAYLOAD);
    localparam logic [TW-1:0] c_tmo_last   = TW'(TMOUT_CYC - 1);

    localparam logic [3:0] c_st_hunt  = 4'd0;
    localparam logic [3:0] c_st_src   = 4'd1;
    localparam logic [3:0] c_st_dst   = 4'd2;
    localparam logic [3:0] c_st_cnt   = 4'd3;
    localparam logic [3:0] c_st_type  = 4'd4;
    localparam logic [3:0] c_st_len   = 4'd5;
    localparam logic [3:0] c_st_data  = 4'd6;
    localparam logic [3:0] c_st_crc   = 4'd7;
    localparam logic [3:0] c_st_stop  = 4'd8;
    localparam logic [3:0] c_st_drain = 4'd9;

    localparam logic [2:0] c_err_none = 3'd0;
    localparam logic [2:0] c_err_par  = 3'd1;
    localparam logic [2:0] c_err_tmo  = 3'd2;
    localparam logic [2:0] c_err_dst  = 3'd3;
    localparam logic [2:0] c_err_cnt  = 3'd4;
    localparam logic [2:0] c_err_crc  = 3'd5;
    localparam logic [2:0] c_err_len  = 3'd6;
    localparam logic [2:0] c_err_stop = 3'd7;

    logic [3:0]       r_state;
    logic [7:0]       r_bcnt;       // delimiter count in HUNT/STOP, field byte index elsewhere
    logic [7:0]       r_crc;
    logic [AW-1:0]    r_src;
    logic [AW-1:0]    r_dst;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    r_prev_cnt;
    logic [7:0]       r_type;
    logic [7:0]       r_len;
    logic [TW-1:0]    r_tmo;
    logic [IDX_W-1:0] r_rd_ptr;
    logic [7:0]       r_buf [0:MAX_PAYLOAD-1];
    logic             r_valid_intr;
    logic [2:0]       r_err_code;
    logic             r_err_valid;
    logic [7:0]       r_out_type;
    logic [AW-1:0]    r_out_src;

    logic             w_acc;
    logic             w_in_frame;
    logic [7:0]       w_crc_next;
    logic [AW-1:0]    w_dst_next;
    logic [CW-1:0]    w_cnt_next;
    logic             w_dst_ok;
    logic             w_rd_last;
    logic [2:0]       w_err_code;
    logic             w_err;

    // Bytewise MSB-first CRC-8 update, init/final handled by the caller
    function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ CRC_POLY) : (c << 1);
        end
        return c;
    endfunction

    assign w_acc      = in_valid && in_ready;
    assign w_in_frame = (r_state >= c_st_src) && (r_state <= c_st_stop);
    assign w_crc_next = crc8_byte(r_crc, in_data);
    assign w_dst_next = AW'({r_dst, in_data});
    assign w_cnt_next = CW'({r_cnt, in_data});
    assign w_dst_ok   = (w_dst_next == dev_addr) ||
                        (BCAST_EN && (w_dst_next == {AW{1'b1}}));
    assign w_rd_last  = (8'(r_rd_ptr) == (r_len - 8'd1));

    assign in_ready   = (r_state != c_st_drain);
    assign out_valid  = (r_state == c_st_drain);
    assign out_data   = (r_state == c_st_drain) ? r_buf[r_rd_ptr] : 8'h00;
    assign out_last   = (r_state == c_st_drain) && w_rd_last;
    assign out_type   = r_out_type;
    assign out_src    = r_out_src;
    assign valid_intr = r_valid_intr;
    assign err_code   = r_err_code;
    assign err_valid  = r_err_valid;

    // Error detection for the current cycle; parity outranks every field check
    always_comb begin
        w_err_code = c_err_none;
        if (w_in_frame) begin
            if (w_acc) begin
                if (in_par_err) begin
                    w_err_code = c_err_par;
                end else begin
                    case (r_state)
                        c_st_dst:  if ((r_bcnt == c_addr_last) && !w_dst_ok)
                                       w_err_code = c_err_dst;
                        c_st_cnt:  if ((r_bcnt == c_cnt_last) && !(w_cnt_next > r_prev_cnt))
                                       w_err_code = c_err_cnt;
                        c_st_len:  if ((in_data == 8'h00) || ({1'b0, in_data} > c_max_len))
                                       w_err_code = c_err_len;
                        c_st_crc:  if (in_data != r_crc)
                                       w_err_code = c_err_crc;
                        c_st_stop: if (in_data != STOP_BYTE)
                                       w_err_code = c_err_stop;
                        default:   w_err_code = c_err_none;
                    endcase
                end
            end else if (r_tmo == c_tmo_last) begin
                // An accepted byte in the expiring cycle takes the branch above
                w_err_code = c_err_tmo;
            end
        end
    end

    assign w_err = (w_err_code != c_err_none);

    // Frame parser, checker, drain sequencer and error/acceptance reporting
    always_ff @(posedge ref_clk or posedge reset) begin
        if (reset) begin
            r_state      <= c_st_hunt;
            r_bcnt       <= 8'd0;
            r_crc        <= 8'h00;
            r_src        <= '0;
            r_dst        <= '0;
            r_cnt        <= '0;
            r_prev_cnt   <= '0;
            r_type       <= 8'h00;
            r_len        <= 8'h00;
            r_tmo        <= '0;
            r_rd_ptr     <= '0;
            r_valid_intr <= 1'b0;
            r_err_code   <= c_err_none;
            r_err_valid  <= 1'b0;
            r_out_type   <= 8'h00;
            r_out_src    <= '0;
        end else begin
            r_valid_intr <= 1'b0;
            r_err_valid  <= 1'b0;
            if (w_err) begin
                r_state     <= c_st_hunt;
                r_bcnt      <= 8'd0;
                r_tmo       <= '0;
                r_err_code  <= w_err_code;
                r_err_valid <= 1'b1;
            end else begin
                case (r_state)
                    c_st_hunt: begin
                        // Parity-errored bytes are ignored while hunting
                        if (w_acc && !in_par_err) begin
                            if (in_data == START_BYTE) begin
                                if (r_bcnt == c_delim_last) begin
                                    r_state <= c_st_src;
                                    r_bcnt  <= 8'd0;
                                    r_crc   <= 8'h00;
                                    r_tmo   <= '0;
                                end else begin
                                    r_bcnt <= r_bcnt + 8'd1;
                                end
                            end else begin
                                r_bcnt <= 8'd0;
                            end
                        end
                    end
                    c_st_drain: begin
                        if (out_ready) begin
                            if (w_rd_last) begin
                                r_state  <= c_st_hunt;
                                r_rd_ptr <= '0;
                                r_bcnt   <= 8'd0;
                            end else begin
                                r_rd_ptr <= r_rd_ptr + 1'b1;
                            end
                        end
                    end
                    default: begin
                        if (w_acc) begin
                            r_tmo <= '0;
                            case (r_state)
                                c_st_src: begin
                                    r_crc <= w_crc_next;
                                    r_src <= AW'({r_src, in_data});
                                    if (r_bcnt == c_addr_last) begin
                                        r_state <= c_st_dst;
                                        r_bcnt  <= 8'd0;
                                    end else begin
                                        r_bcnt <= r_bcnt + 8'd1;
                                    end
                                end
                                c_st_dst: begin
                                    r_crc <= w_crc_next;
                                    r_dst <= w_dst_next;
                                    if (r_bcnt == c_addr_last) begin
                                        r_state <= c_st_cnt;
                                        r_bcnt  <= 8'd0;
                                    end else begin
                                        r_bcnt <= r_bcnt + 8'd1;
                                    end
                                end
                                c_st_cnt: begin
                                    r_crc <= w_crc_next;
                                    r_cnt <= w_cnt_next;
                                    if (r_bcnt == c_cnt_last) begin
                                        r_state <= c_st_type;
                                        r_bcnt  <= 8'd0;
                                    end else begin
                                        r_bcnt <= r_bcnt + 8'd1;
                                    end
                                end
                                c_st_type: begin
                                    r_crc   <= w_crc_next;
                                    r_type  <= in_data;
                                    r_state <= c_st_len;
                                end
                                c_st_len: begin
                                    r_crc   <= w_crc_next;
                                    r_len   <= in_data;
                                    r_bcnt  <= 8'd0;
                                    r_state <= c_st_data;
                                end
                                c_st_data: begin
                                    r_crc <= w_crc_next;
                                    if (r_bcnt == (r_len - 8'd1)) begin
                                        r_state <= c_st_crc;
                                        r_bcnt  <= 8'd0;
                                    end else begin
                                        r_bcnt <= r_bcnt + 8'd1;
                                    end
                                end
                                c_st_crc: begin
                                    r_state <= c_st_stop;
                                    r_bcnt  <= 8'd0;
                                end
                                c_st_stop: begin
                                    if (r_bcnt == c_delim_last) begin
                                        r_valid_intr <= 1'b1;
                                        r_prev_cnt   <= r_cnt;
                                        r_out_type   <= r_type;
                                        r_out_src    <= r_src;
                                        r_rd_ptr     <= '0;
                                        r_bcnt       <= 8'd0;
                                        r_state      <= c_st_drain;
                                    end else begin
                                        r_bcnt <= r_bcnt + 8'd1;
                                    end
                                end
                                default: r_state <= c_st_hunt;
                            endcase
                        end else begin
                            r_tmo <= r_tmo + 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    // Payload buffer: DATA bytes land at their position within the payload
    always_ff @(posedge ref_clk) begin
        if ((r_state == c_st_data) && w_acc && !in_par_err) begin
            r_buf[IDX_W'(r_bcnt)] <= in_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pkt_rx_framer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_pkt_rx_framer
//  Purpose  : Scoreboard bench for pkt_rx_framer; directed frames, expected
//             payload/errors queued at issue time, monitor compares outputs.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pkt_rx_framer;

    localparam int TMO = 100;

    logic        ref_clk = 1'b0;
    logic        reset;
    logic [15:0] dev_addr;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_par_err;
    logic        in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic [7:0]  out_type;
    logic [15:0] out_src;
    logic        valid_intr;
    logic [2:0]  err_code;
    logic        err_valid;

    always #5 ref_clk = ~ref_clk;

    pkt_rx_framer #(
        .ADDR_BYTES (2),
        .CNT_BYTES  (4),
        .MAX_PAYLOAD(16),
        .START_BYTE (8'hAA),
        .STOP_BYTE  (8'h55),
        .DELIM_LEN  (2),
        .CRC_POLY   (8'h07),
        .TMOUT_CYC  (TMO),
        .BCAST_EN   (1'b1)
    ) dut (
        .ref_clk   (ref_clk),
        .reset     (reset),
        .dev_addr  (dev_addr),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_par_err(in_par_err),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .out_type  (out_type),
        .out_src   (out_src),
        .valid_intr(valid_intr),
        .err_code  (err_code),
        .err_valid (err_valid)
    );

    typedef struct packed {
        logic [7:0]  data;
        logic        last;
        logic [7:0]  typ;
        logic [15:0] src;
    } out_t;

    out_t       exp_out[$];
    logic [2:0] exp_err[$];
    int         exp_intr = 0;
    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         last_acc_cyc = 0;
    int         err_cyc = -1;
    logic       toggle_rdy = 1'b0;
    logic       ov_pending = 1'b0;
    logic [7:0] fb[$];
    logic [7:0] dat[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference CRC-8, bit-serial formulation
    function automatic logic [7:0] crc_model(input logic [7:0] crc, input logic [7:0] b);
        logic [7:0] r;
        logic       fbit;
        r = crc;
        for (int i = 7; i >= 0; i--) begin
            fbit = r[7] ^ b[i];
            r    = {r[6:0], 1'b0};
            if (fbit) r = r ^ 8'h07;
        end
        return r;
    endfunction

    always @(posedge ref_clk) cyc <= cyc + 1;

    // Consumer: always ready, or alternating 1-0-1 when toggle_rdy is set
    always @(posedge ref_clk) begin
        #1;
        out_ready = toggle_rdy ? ~out_ready : 1'b1;
    end

    // Monitor: compares DUT outputs against the scoreboard queues
    always @(negedge ref_clk) begin
        if (!reset) begin
            if (ov_pending) chk("out_valid_held", out_valid, 1);
            if (out_valid) chk("in_ready_low_in_drain", in_ready, 0);
            if (valid_intr) begin
                chk("valid_intr_expected", exp_intr > 0, 1);
                chk("out_valid_with_intr", out_valid, 1);
                if (exp_intr > 0) exp_intr--;
            end
            if (out_valid && out_ready) begin
                if (exp_out.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_out: got data %0h, none expected", out_data);
                end else begin
                    out_t e;
                    e = exp_out.pop_front();
                    chk("out_data", out_data, e.data);
                    chk("out_last", out_last, e.last);
                    chk("out_type", out_type, e.typ);
                    chk("out_src", out_src, e.src);
                end
            end
            if (err_valid) begin
                err_cyc = cyc;
                if (exp_err.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_err: got code %0d, none expected", err_code);
                end else begin
                    chk("err_code", err_code, exp_err.pop_front());
                end
            end
            ov_pending = out_valid && !out_ready;
        end else begin
            ov_pending = 1'b0;
        end
    end

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge ref_clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic par);
        int n;
        n          = 0;
        in_data    = b;
        in_par_err = par;
        in_valid   = 1'b1;
        while (!in_ready && n < 1000) begin
            @(posedge ref_clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL in_ready_wait: got in_ready 0 expected 1 after %0d cycles", n);
        end
        @(posedge ref_clk);
        #1;
        last_acc_cyc = cyc;
        in_valid     = 1'b0;
        in_par_err   = 1'b0;
    endtask

    // Frame bytes into fb from the current dat[] payload; len may disagree with dat
    task automatic build_frame(input logic [15:0] src, input logic [15:0] dst,
                               input logic [31:0] cnt, input logic [7:0] typ,
                               input logic [7:0] len, input logic [7:0] crc_xor);
        logic [7:0] c;
        c = 8'h00;
        fb.delete();
        fb.push_back(8'hAA); fb.push_back(8'hAA);
        fb.push_back(src[15:8]); fb.push_back(src[7:0]);
        fb.push_back(dst[15:8]); fb.push_back(dst[7:0]);
        fb.push_back(cnt[31:24]); fb.push_back(cnt[23:16]);
        fb.push_back(cnt[15:8]);  fb.push_back(cnt[7:0]);
        fb.push_back(typ);
        fb.push_back(len);
        foreach (dat[i]) fb.push_back(dat[i]);
        for (int i = 2; i < fb.size(); i++) c = crc_model(c, fb[i]);
        fb.push_back(c ^ crc_xor);
        fb.push_back(8'h55); fb.push_back(8'h55);
    endtask

    task automatic send_range(input int from, input int to, input int par_idx);
        for (int i = from; i <= to; i++) send_byte(fb[i], i == par_idx);
    endtask

    task automatic push_ok(input logic [15:0] src, input logic [7:0] typ);
        out_t e;
        foreach (dat[i]) begin
            e.data = dat[i];
            e.last = (i == dat.size() - 1);
            e.typ  = typ;
            e.src  = src;
            exp_out.push_back(e);
        end
        exp_intr++;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while ((exp_out.size() != 0 || exp_err.size() != 0 || exp_intr != 0) && n < 2000) begin
            @(posedge ref_clk);
            #1;
            n++;
        end
        if (exp_out.size() != 0 || exp_err.size() != 0 || exp_intr != 0) begin
            total++;
            bad++;
            $display("FAIL drain_wait: got %0d bytes %0d errors %0d intr pending expected none",
                     exp_out.size(), exp_err.size(), exp_intr);
            exp_out.delete();
            exp_err.delete();
            exp_intr = 0;
        end
        idle(3);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"},   in_ready,   1);
        chk({tag, "_out_valid"},  out_valid,  0);
        chk({tag, "_out_last"},   out_last,   0);
        chk({tag, "_valid_intr"}, valid_intr, 0);
        chk({tag, "_err_valid"},  err_valid,  0);
        chk({tag, "_err_code"},   err_code,   0);
        chk({tag, "_out_data"},   out_data,   0);
        chk({tag, "_out_type"},   out_type,   0);
        chk({tag, "_out_src"},    out_src,    0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before 500us");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        dev_addr   = 16'h0123;
        in_data    = 8'h00;
        in_valid   = 1'b0;
        in_par_err = 1'b0;
        out_ready  = 1'b1;
        repeat (3) @(posedge ref_clk);
        #1;
        check_reset_outputs("reset");
        reset = 1'b0;
        idle(2);

        // Good frame
        dat = '{8'h11, 8'h22, 8'h33};
        build_frame(16'h0456, 16'h0123, 32'h1, 8'h50, 8'd3, 8'h00);
        push_ok(16'h0456, 8'h50);
        send_range(0, fb.size() - 1, -1);
        wait_done();

        // Counter not increasing
        build_frame(16'h0456, 16'h0123, 32'h1, 8'h50, 8'd3, 8'h00);
        exp_err.push_back(3'd4);
        send_range(0, fb.size() - 1, -1);
        wait_done();

        build_frame(16'h0456, 16'h0123, 32'h2, 8'h50, 8'd3, 8'h00);
        push_ok(16'h0456, 8'h50);
        send_range(0, fb.size() - 1, -1);
        wait_done();

        // Bad CRC, then same counter accepted
        dat = '{8'h01, 8'h02};
        build_frame(16'h0789, 16'h0123, 32'h3, 8'h51, 8'd2, 8'h01);
        exp_err.push_back(3'd5);
        send_range(0, fb.size() - 1, -1);
        wait_done();

        build_frame(16'h0789, 16'h0123, 32'h3, 8'h51, 8'd2, 8'h00);
        push_ok(16'h0789, 8'h51);
        send_range(0, fb.size() - 1, -1);
        wait_done();

        // Wrong address, then broadcast with a one-byte payload
        build_frame(16'h0456, 16'h0124, 32'h4, 8'h50, 8'd2, 8'h00);
        exp_err.push_back(3'd3);
        send_range(0, fb.size() - 1, -1);
        wait_done();

        dat = '{8'h7E};
        build_frame(16'h0ABC, 16'hFFFF, 32'h4, 8'h60, 8'd1, 8'h00);
        push_ok(16'h0ABC, 8'h60);
        send_range(0, fb.size() - 1, -1);
        wait_done();

        // Length out of range
        dat.delete();
        build_frame(16'h0456, 16'h0123, 32'h5, 8'h50, 8'd0, 8'h00);
        exp_err.push_back(3'd6);
        send_range(0, fb.size() - 1, -1);
        wait_done();

        build_frame(16'h0456, 16'h0123, 32'h5, 8'h50, 8'd17, 8'h00);
        exp_err.push_back(3'd6);
        send_range(0, fb.size() - 1, -1);
        wait_done();

        // Stall after the second DATA byte: error 100 cycles after that byte
        dat = '{8'h11, 8'h22, 8'h33};
        build_frame(16'h0456, 16'h0123, 32'h5, 8'h50, 8'd3, 8'h00);
        exp_err.push_back(3'd2);
        err_cyc = -1;
        send_range(0, 13, -1);
        idle(TMO + 5);
        chk("timeout_latency", err_cyc - last_acc_cyc, TMO);
        wait_done();

        // Next byte accepted in the very cycle the counter would expire
        build_frame(16'h0456, 16'h0123, 32'h5, 8'h50, 8'd3, 8'h00);
        push_ok(16'h0456, 8'h50);
        send_range(0, 13, -1);
        idle(TMO - 1);
        send_range(14, fb.size() - 1, -1);
        wait_done();

        // Parity error on TYPE
        build_frame(16'h0456, 16'h0123, 32'h6, 8'h50, 8'd3, 8'h00);
        exp_err.push_back(3'd1);
        send_range(0, fb.size() - 1, 10);
        wait_done();

        // Drain with out_ready alternating
        dat = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65};
        build_frame(16'h0321, 16'h0123, 32'h6, 8'h70, 8'd5, 8'h00);
        push_ok(16'h0321, 8'h70);
        toggle_rdy = 1'b1;
        send_range(0, fb.size() - 1, -1);
        wait_done();
        toggle_rdy = 1'b0;
        idle(2);

        // Full-size payload
        dat.delete();
        for (int i = 0; i < 16; i++) dat.push_back(8'h30 + 8'(i));
        build_frame(16'h0456, 16'h0123, 32'h7, 8'h52, 8'd16, 8'h00);
        push_ok(16'h0456, 8'h52);
        send_range(0, fb.size() - 1, -1);
        wait_done();

        // Reset mid-DATA discards the frame and clears prev_cnt
        dat = '{8'h11, 8'h22, 8'h33};
        build_frame(16'h0456, 16'h0123, 32'h8, 8'h50, 8'd3, 8'h00);
        send_range(0, 13, -1);
        reset = 1'b1;
        #1;
        check_reset_outputs("midreset");
        repeat (2) @(posedge ref_clk);
        #1;
        reset = 1'b0;
        idle(2);

        build_frame(16'h0456, 16'h0123, 32'h1, 8'h50, 8'd3, 8'h00);
        push_ok(16'h0456, 8'h50);
        send_range(0, fb.size() - 1, -1);
        wait_done();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pkt_rx_framer.md
Name: pkt_rx_framer

Overview:
- Parametrised byte-level packet receiver/validator. Sits between the UART byte receiver (parallel byte plus parity flag) and the packet consumer.
- Parses framed packets with a variable-length payload, checks destination address, packet-counter monotonicity and CRC-8, and buffers the payload.
- Releases the payload through a ready/valid stream only after the complete frame, including the stop bytes, has been verified.
- Successor to the fixed 18-byte receiver: generic field widths, a length field, broadcast, buffered output and explicit error reporting.

Parameters:
- ADDR_BYTES, 2, bytes in each of the SRC and DST fields, MSB first.
- CNT_BYTES, 4, bytes in the packet counter, MSB first, unsigned.
- MAX_PAYLOAD, 16, payload buffer depth in bytes; LEN must be 1..MAX_PAYLOAD.
- START_BYTE, 8'hAA, start delimiter value.
- STOP_BYTE, 8'h55, stop delimiter value.
- DELIM_LEN, 2, number of start bytes and number of stop bytes.
- CRC_POLY, 8'h07, CRC-8 polynomial (x^8 implicit). MSB-first, init 8'h00, no reflection, no final XOR.
- TMOUT_CYC, 5000000, ref_clk cycles allowed between bytes inside a frame.
- BCAST_EN, 1, when 1, DST of all-ones is accepted.

Ports:
- ref_clk, input, 1, clock.
- reset, input, 1, asynchronous active-high reset.
- dev_addr, input, 8*ADDR_BYTES, device address; sampled when the last DST byte is received.
- in_data, input, 8, received byte.
- in_valid, input, 1, in_data valid; accepted when in_valid && in_ready.
- in_par_err, input, 1, parity error flag qualified by in_valid.
- in_ready, output, 1, byte-accept handshake.
- out_data, output, 8, payload byte.
- out_valid, output, 1, payload byte valid.
- out_ready, input, 1, consumer ready.
- out_last, output, 1, marks the final payload byte.
- out_type, output, 8, TYPE of the frame being drained.
- out_src, output, 8*ADDR_BYTES, SRC of the frame being drained.
- valid_intr, output, 1, one-cycle pulse on frame acceptance.
- err_code, output, 3, last error code; held until the next error or reset.
- err_valid, output, 1, one-cycle pulse with each new err_code.

Behaviour:
- Reset (async, active-high):
  - state=HUNT; all counters, CRC accumulator, prev_cnt and buffer pointers cleared.
  - Outputs: in_ready=1, out_valid=0, out_last=0, valid_intr=0, err_valid=0, err_code=0, out_data/out_type/out_src=0.
  - Reset mid-frame or mid-drain discards everything.
- Frame order: START×DELIM_LEN, SRC, DST, CNT, TYPE, LEN, DATA×LEN, CRC, STOP×DELIM_LEN.
- States: HUNT, SRC, DST, CNT, TYPE, LEN, DATA, CRC, STOP, DRAIN. A byte counter tracks position within multi-byte fields.
- HUNT:
  - A byte != START_BYTE resets the delimiter count to 0 and stays in HUNT; no error is raised.
  - DELIM_LEN consecutive START_BYTE bytes -> SRC, with CRC cleared to 0.
- CRC accumulation: every byte accepted from SRC through the last DATA byte updates the CRC in the same cycle (bytewise combinational update). In CRC state, received byte != accumulated CRC -> error 5.
- DST complete: passes if it equals dev_addr, or if BCAST_EN and it is all-ones; otherwise error 3.
- CNT complete: passes if CNT > prev_cnt (unsigned, CNT_BYTES wide); otherwise error 4. prev_cnt is updated only on frame acceptance.
- LEN: 0 or > MAX_PAYLOAD -> error 6. DATA bytes are written to the buffer at addresses 0..LEN-1.
- STOP: any byte != STOP_BYTE -> error 7. After DELIM_LEN correct stop bytes:
  - valid_intr pulses;
  - prev_cnt <= CNT;
  - out_type and out_src are latched;
  - state -> DRAIN.
- DRAIN:
  - in_ready=0.
  - out_valid=1 from the cycle after acceptance; out_data = buf[rd_ptr].
  - rd_ptr advances on out_valid && out_ready; out_last=1 when rd_ptr==LEN-1.
  - The final handshake -> HUNT with in_ready=1 the next cycle.
  - out_valid must not drop without a handshake.
- Errors, common actions: set err_code, pulse err_valid for 1 cycle, discard the frame and go to HUNT. prev_cnt is unchanged and no payload is emitted.
- Parity error: an accepted byte with in_par_err=1 in any state except HUNT/DRAIN -> error 1. This has priority over all other checks on that byte. In HUNT, parity-errored bytes are dropped silently.
- Timeout:
  - Counter runs in states SRC..STOP and clears on every accepted byte.
  - Reaching TMOUT_CYC -> error 2.
  - If a byte is accepted in the same cycle the counter would expire, the byte wins and the counter clears.
  - The counter does not run in HUNT or DRAIN.
- Latency: valid_intr fires in the cycle after the last stop byte is accepted; the first out_valid appears in the same cycle as valid_intr.
- Width rules: CNT compare at full CNT_BYTES*8 width; buffer index width clog2(MAX_PAYLOAD); no wrap on prev_cnt (saturating counters are the sender's concern).

Test Plan:
- Good frame: SRC=16'h0456, DST=16'h0123 (dev_addr=16'h0123), CNT=32'h1, TYPE=8'h50, LEN=3, DATA=11 22 33, model-computed CRC, 55 55. Required: valid_intr=1 pulse; out stream 11,22,33 with out_last on 33; out_type=50; out_src=0456; err_valid never asserted.
- Same frame repeated with CNT=32'h1: err_code=4, err_valid pulse, no out_valid. Then CNT=32'h2 -> accepted.
- CRC byte XOR 8'h01: err_code=5; prev_cnt unchanged, so a follow-up frame with the same CNT is accepted.
- DST=16'h0124 -> err_code=3. DST=16'hFFFF with BCAST_EN=1 -> accepted. LEN=0 -> err_code=6. LEN=17 -> err_code=6.
- Stall after the 2nd DATA byte for TMOUT_CYC (TMOUT_CYC=100 in the bench) -> err_code=2 at cycle 100. Byte arriving at cycle 99 -> no error. in_par_err on the TYPE byte -> err_code=1.
- Drain with out_ready toggled 1-0-1 per cycle: in_ready=0 throughout, no byte lost or duplicated. Reset asserted mid-DATA -> all outputs return to reset values, then a good frame is accepted with CNT=32'h1.
